// File: rtl/button_debouncer.sv
// button_debouncer: per-button 2-flop synchroniser and debounce FSM producing a clean level and a press pulse.
// Define AUTOREPEAT_EN to re-issue the press pulse while a button is held (REPEAT_DELAY, then every REPEAT_PERIOD).
module button_debouncer #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_WAIT_PRESS   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

`ifdef AUTOREPEAT_EN
    localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCNT_W = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RCNT_W-1:0] RCNT_ZERO   = RCNT_W'(0);
    localparam logic [RCNT_W-1:0] RCNT_ONE    = RCNT_W'(1);
    localparam logic [RCNT_W-1:0] RCNT_DELAY  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RCNT_PERIOD = RCNT_W'(REPEAT_PERIOD - 1);
`endif

    // A one-cycle counter terminal would make "stable" meaningless, and repeat timings need at least one cycle.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("button_debouncer: DEBOUNCE_CYCLES must be >= 2 and REPEAT_* >= 1");
    end

    logic [N_BTN-1:0] s1_r;
    logic [N_BTN-1:0] s2_r;

    // Two-flop synchroniser for the asynchronous raw buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= {N_BTN{1'b0}};
            s2_r <= {N_BTN{1'b0}};
        end else begin
            s1_r <= btn_in;
            s2_r <= s1_r;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        logic [1:0]       state_r;
        logic [1:0]       state_nxt_s;
        logic [CNT_W-1:0] cnt_r;
        logic [CNT_W-1:0] cnt_nxt_s;
        logic             level_r;
        logic             level_nxt_s;
        logic             pulse_r;
        logic             pulse_nxt_s;
        logic             in_s;
`ifdef AUTOREPEAT_EN
        logic [RCNT_W-1:0] rcnt_r;
        logic [RCNT_W-1:0] rcnt_nxt_s;
        logic              rep_seen_r;
        logic              rep_seen_nxt_s;
        logic [RCNT_W-1:0] rcnt_lim_s;
`endif

        assign in_s = s2_r[g];

        // Debounce FSM next-state; pulse defaults low so it lasts exactly one cycle.
        always_comb begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
            level_nxt_s = level_r;
            pulse_nxt_s = 1'b0;
`ifdef AUTOREPEAT_EN
            rcnt_nxt_s     = RCNT_ZERO;
            rep_seen_nxt_s = 1'b0;
            rcnt_lim_s     = rep_seen_r ? RCNT_PERIOD : RCNT_DELAY;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (in_s) begin
                        state_nxt_s = ST_WAIT_PRESS;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_WAIT_PRESS: begin
                    if (!in_s) begin
                        state_nxt_s = ST_IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        state_nxt_s = ST_PRESSED;
                        level_nxt_s = 1'b1;
                        pulse_nxt_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    if (!in_s) begin
                        state_nxt_s = ST_WAIT_RELEASE;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = ST_PRESSED;
`ifdef AUTOREPEAT_EN
                        // First repeat after REPEAT_DELAY, later ones every REPEAT_PERIOD.
                        if (rcnt_r == rcnt_lim_s) begin
                            pulse_nxt_s    = 1'b1;
                            rcnt_nxt_s     = RCNT_ZERO;
                            rep_seen_nxt_s = 1'b1;
                        end else begin
                            rcnt_nxt_s     = rcnt_r + RCNT_ONE;
                            rep_seen_nxt_s = rep_seen_r;
                        end
`endif
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (in_s) begin
                        state_nxt_s = ST_PRESSED;
                    end else if (cnt_r == CNT_LAST) begin
                        state_nxt_s = ST_IDLE;
                        level_nxt_s = 1'b0;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                    level_nxt_s = 1'b0;
                end
            endcase
        end

        // Channel state and registered outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r <= ST_IDLE;
                cnt_r   <= CNT_ZERO;
                level_r <= 1'b0;
                pulse_r <= 1'b0;
            end else begin
                state_r <= state_nxt_s;
                cnt_r   <= cnt_nxt_s;
                level_r <= level_nxt_s;
                pulse_r <= pulse_nxt_s;
            end
        end

`ifdef AUTOREPEAT_EN
        // Repeat counter is zero outside PRESSED, so every entry to PRESSED restarts the delay.
        always_ff @(posedge clk) begin
            if (rst) begin
                rcnt_r     <= RCNT_ZERO;
                rep_seen_r <= 1'b0;
            end else begin
                rcnt_r     <= rcnt_nxt_s;
                rep_seen_r <= rep_seen_nxt_s;
            end
        end
`endif

        assign btn_level[g] = level_r;
        assign btn_pulse[g] = pulse_r;
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed self-checking bench for button_debouncer with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
module tb_button_debouncer;

    localparam int N = 5;

    logic         clk;
    logic         rst;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_pulse;

    int n_total = 0;
    int n_pass  = 0;

    button_debouncer #(
        .N_BTN(N),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(8),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk2(input string tag, input logic [N-1:0] lvl, input logic [N-1:0] pls);
        chk({tag, "_level"}, btn_level, lvl);
        chk({tag, "_pulse"}, btn_pulse, pls);
    endtask

    initial begin
        rst    = 1'b1;
        btn_in = 5'b11111;
        step(1);
        chk2("rst_during1", 5'b00000, 5'b00000);
        step(1);
        chk2("rst_during2", 5'b00000, 5'b00000);
        rst    = 1'b0;
        btn_in = 5'b00000;
        step(1);
        chk2("rst_exit", 5'b00000, 5'b00000);
        step(3);
        chk2("idle", 5'b00000, 5'b00000);

        // Single press on channel 0
        btn_in[0] = 1'b1;
        step(6);
        chk2("p0_edge6", 5'b00000, 5'b00000);
        step(1);
        chk2("p0_edge7", 5'b00001, 5'b00001);
        for (int k = 8; k <= 20; k++) begin
            step(1);
            chk2("p0_hold", 5'b00001, 5'b00000);
        end
        btn_in[0] = 1'b0;
        step(6);
        chk2("r0_edge6", 5'b00001, 5'b00000);
        step(1);
        chk2("r0_edge7", 5'b00000, 5'b00000);
        step(3);

        // Short glitches on channel 1 never qualify
        btn_in[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin step(1); chk2("g1_hi_a", 5'b00000, 5'b00000); end
        btn_in[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin step(1); chk2("g1_lo", 5'b00000, 5'b00000); end
        btn_in[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin step(1); chk2("g1_hi_b", 5'b00000, 5'b00000); end
        btn_in[1] = 1'b0;
        for (int k = 0; k < 10; k++) begin step(1); chk2("g1_tail", 5'b00000, 5'b00000); end

        // Channel 2: press, release bounce ignored, then real release
        btn_in[2] = 1'b1;
        step(7);
        chk2("p2_press", 5'b00100, 5'b00100);
        step(1);
        chk2("p2_after", 5'b00100, 5'b00000);
        btn_in[2] = 1'b0;
        step(2);
        chk2("p2_bounce_lo", 5'b00100, 5'b00000);
        btn_in[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin step(1); chk2("p2_bounce", 5'b00100, 5'b00000); end
        btn_in[2] = 1'b0;
        step(6);
        chk2("r2_edge6", 5'b00100, 5'b00000);
        step(1);
        chk2("r2_edge7", 5'b00000, 5'b00000);
        step(3);
        chk2("r2_idle", 5'b00000, 5'b00000);

        // Simultaneous presses on channels 0, 2, 4
        btn_in = 5'b10101;
        step(6);
        chk2("multi_edge6", 5'b00000, 5'b00000);
        step(1);
        chk2("multi_edge7", 5'b10101, 5'b10101);
        step(1);
        chk2("multi_edge8", 5'b10101, 5'b00000);
        btn_in = 5'b00000;
        step(7);
        chk2("multi_release", 5'b00000, 5'b00000);
        step(2);

        // Reset while channel 3 is mid-count in WAIT_PRESS
        btn_in[3] = 1'b1;
        step(5);
        chk2("c3_pre_rst", 5'b00000, 5'b00000);
        rst = 1'b1;
        step(1);
        chk2("c3_in_rst", 5'b00000, 5'b00000);
        rst = 1'b0;
        step(6);
        chk2("c3_edge6", 5'b00000, 5'b00000);
        step(1);
        chk2("c3_edge7", 5'b01000, 5'b01000);
        for (int k = 1; k <= 30; k++) begin
            logic [N-1:0] exp_p;
            exp_p = 5'b00000;
`ifdef AUTOREPEAT_EN
            if (k == 8 || (k > 8 && ((k - 8) % 3) == 0)) exp_p = 5'b01000;
`endif
            step(1);
            chk2("c3_hold", 5'b01000, exp_p);
        end
        btn_in[3] = 1'b0;
        step(7);
        chk2("c3_release", 5'b00000, 5'b00000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
